instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Producer end of the opcode interface into instruction_decoder: fetches byte-wide instructions from program memory and issues them via valid/ready.
//  Assembles two-byte instructions (opcode + operand); maintains the PC; applies redirects from execute.
//  Sits between program memory and the decode/execute stage.
// PARAMETERS
//  ADDR_W    16       program address width (bits)
//  RESET_PC  'h0000   PC value loaded on reset (ADDR_W bits)
// PORTS
//  clk             in   1       single clock, all state on posedge
//  rst             in   1       synchronous, active-high reset
//  en              in   1       run enable; 0 = stop after current instruction issues
//  mem_req         out  1       read request; high in FETCH_OP/FETCH_ARG
//  mem_addr        out  ADDR_W  read address (= pc); stable while mem_req high
//  mem_ack         in   1       mem_rdata valid for current mem_addr this cycle; same-cycle ack allowed
//  mem_rdata       in   8       read data byte
//  instr_valid     out  1       issued instruction available
//  instr_ready     in   1       decoder/execute accepts instruction
//  instr_opcode    out  8       opcode byte (to instruction_decoder.opcode)
//  instr_operand   out  8       operand byte; 8'h00 for one-byte instructions
//  instr_pc        out  ADDR_W  address of the opcode byte
//  redirect_valid  in   1       branch taken / jump: reload PC (1-cycle pulse)
//  redirect_addr   in   ADDR_W  new PC
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0.
//  Encoding: 8'h08 LOAD, 8'h09 STORE, 8'h10 BRANCH, 8'h11 JUMP = two bytes (opcode, operand);
//   all other values (ALU ops, undefined) = one byte; undefined issues normally (decoder treats as NOP).
//  States: IDLE, FETCH_OP, FETCH_ARG, ISSUE. mem_req = (state==FETCH_OP || state==FETCH_ARG), mem_addr = pc.
//   IDLE: en=1 -> FETCH_OP.
//   FETCH_OP: mem_ack -> opcode<=mem_rdata, instr_pc<=pc, pc<=pc+1; two-byte -> FETCH_ARG, else operand<=0 -> ISSUE.
//   FETCH_ARG: mem_ack -> operand<=mem_rdata, pc<=pc+1 -> ISSUE.
//   ISSUE: instr_valid=1; opcode/operand/instr_pc held stable until instr_valid&&instr_ready;
//    on transfer -> FETCH_OP if en else IDLE.
//  Exactly one request outstanding; no prefetch. Waits indefinitely for mem_ack / instr_ready.
//  Latency (zero-wait memory, ready=1): one-byte instr every 2 cycles, two-byte every 3.
//   en rising in IDLE -> mem_req next cycle -> instr_valid 1 cycle after ack.
//  en=0 mid-fetch: current instruction completes fetch and issue, then IDLE; pc retains next address.
//  redirect_valid (highest priority, any state):
//   pc<=redirect_addr; state<=FETCH_OP if en else IDLE; instr_valid=0 next cycle.
//   mem_ack in the same cycle is discarded (pc not incremented, no capture).
//   In ISSUE, a transfer in the same cycle as redirect counts as completed.
//   Redirect in IDLE only loads pc.
//  PC arithmetic modulo 2^ADDR_W: pc 'hFFFF + 1 -> 'h0000; a two-byte instr may straddle the wrap.
//  rst overrides redirect and all activity; mid-operation reset returns to reset values next cycle, in-flight data dropped.
// TESTING
//  1. rst, en=1, mem[0]=8'h01, mem[1]=8'h02, zero-wait, ready=1 -> issue {01,00,pc0} then {02,00,pc1}, 2 cycles apart.
//  2. mem[0..1]=08,5A, ack delayed 3 cycles per byte -> one issue {08,5A,pc0}; mem_addr stable while mem_req high; next fetch pc=2.
//  3. instr_ready=0 for 5 cycles in ISSUE -> instr_valid held, outputs stable, mem_req=0; transfer on ready=1.
//  4. redirect_valid to 'h0040 during FETCH_ARG with same-cycle ack -> ack discarded, next mem_addr='h0040, no partial instruction issued.
//  5. RESET_PC='hFFFF, mem[FFFF]=11, mem[0000]=33 -> issue {11,33,FFFF}; next fetch addr 'h0001.
//  6. en=0 while in FETCH_OP -> instruction completes and issues, then IDLE, mem_req=0; rst mid-WAIT -> all outputs to reset values.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches 1/2-byte instructions from program memory and issues them over valid/ready
module instruction_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
);
    typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_ARG, ISSUE} state_t;
    localparam logic [ADDR_W-1:0] ONE = 1;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              two_byte;
    assign two_byte    = mem_rdata inside {8'h08, 8'h09, 8'h10, 8'h11};
    assign mem_req     = state == FETCH_OP || state == FETCH_ARG;
    assign mem_addr    = pc;
    assign instr_valid = state == ISSUE;
    // fetch/issue sequencer; redirect preempts everything but reset and drops any same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr_opcode  <= '0;
            instr_operand <= '0;
            instr_pc      <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_addr;
            state <= en ? FETCH_OP : IDLE;
        end else begin
            case (state)
                IDLE: state <= en ? FETCH_OP : IDLE;
                FETCH_OP: if (mem_ack) begin
                    instr_opcode <= mem_rdata;
                    instr_pc     <= pc;
                    pc           <= pc + ONE;
                    if (!two_byte) instr_operand <= '0;
                    state <= two_byte ? FETCH_ARG : ISSUE;
                end
                FETCH_ARG: if (mem_ack) begin
                    instr_operand <= mem_rdata;
                    pc            <= pc + ONE;
                    state         <= ISSUE;
                end
                default: if (instr_ready) state <= en ? FETCH_OP : IDLE;
            endcase
        end
    end
endmodule
